nal_unit_assembler: RTL

- Byte-stream front end that feeds the slice decoder.
- Hunts Annex-B start codes (00 00 01), strips emulation-prevention bytes (00 00 03 -> 00 00), and packs one NAL payload MSB-first into a 3072-bit window.
- Presents each completed NAL with a one-cycle start pulse, a byte length and an error flag.

---
 rtl/nal_unit_assembler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/nal_unit_assembler.sv
// nal_unit_assembler: Annex-B byte-stream front end for the slice decoder.
// Hunts 00 00 01 start codes, strips 00 00 03 emulation-prevention bytes and
// packs one NAL payload MSB-first into an output window with start/len/error.
// Optional build macro NAL_SLICE_FILTER_EN drops NALs whose nal_unit_type is
// outside 1..5 instead of emitting them.
module nal_unit_assembler #(
  parameter int unsigned NAL_BYTES = 384,
  parameter int unsigned LEN_W     = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   start,
  output logic [8*NAL_BYTES-1:0] nal_unit,
  output logic [LEN_W-1:0]       nal_len,
  output logic                   error
);

  localparam int unsigned IDX_W = $clog2(NAL_BYTES);
  localparam int unsigned SUM_W = LEN_W + 2;
  localparam int unsigned UNI_W = 8 * NAL_BYTES;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       zero_cnt_q;
  logic [LEN_W-1:0] byte_cnt_q;
  logic             ovf_q;
  logic             perr_q;
  logic             done_last_q;
  logic [7:0]       buf_q [NAL_BYTES];

  logic             accept;
  logic             is_zero;
  logic             is_sc;
  logic [1:0]       wr_n;
  logic [7:0]       wb [3];
  logic [SUM_W-1:0] widx [3];
  logic             perr_set;
  logic [1:0]       zc_inc;
  logic [SUM_W-1:0] cnt_sum;
  logic [LEN_W-1:0] cnt_sat;
  logic             ovf_set;
  logic             fill_nonempty;
  logic             keep;
  logic             emit_fire;
  logic             emit_leave;
  logic [UNI_W-1:0] buf_flat;

  assign accept = in_valid && (state_q != EMIT);

  // Classify the incoming byte against the pending zero run and build the write burst
  always_comb begin
    is_zero  = (in_data == 8'h00);
    is_sc    = (in_data == 8'h01) && (zero_cnt_q >= 2'd2);
    wr_n     = 2'd0;
    wb[0]    = in_data;
    wb[1]    = 8'h00;
    wb[2]    = 8'h00;
    perr_set = 1'b0;
    if (is_zero || is_sc) begin
      wr_n = 2'd0;
    end else if ((in_data == 8'h03) && (zero_cnt_q == 2'd2)) begin
      wr_n  = 2'd2;
      wb[0] = 8'h00;
      wb[1] = 8'h00;
    end else begin
      case (zero_cnt_q)
        2'd0: begin
          wr_n  = 2'd1;
          wb[0] = in_data;
        end
        2'd1: begin
          wr_n  = 2'd2;
          wb[0] = 8'h00;
          wb[1] = in_data;
        end
        2'd2: begin
          wr_n  = 2'd3;
          wb[0] = 8'h00;
          wb[1] = 8'h00;
          wb[2] = in_data;
        end
        default: begin
          // Three or more zeros before a non-start-code byte is malformed
          wr_n     = 2'd1;
          wb[0]    = in_data;
          perr_set = 1'b1;
        end
      endcase
    end
    zc_inc  = (zero_cnt_q == 2'd3) ? 2'd3 : zero_cnt_q + 2'd1;
    for (int k = 0; k < 3; k++) begin
      widx[k] = SUM_W'(byte_cnt_q) + SUM_W'(k);
    end
    cnt_sum       = SUM_W'(byte_cnt_q) + SUM_W'(wr_n);
    ovf_set       = (cnt_sum > SUM_W'(NAL_BYTES));
    cnt_sat       = ovf_set ? LEN_W'(NAL_BYTES) : cnt_sum[LEN_W-1:0];
    fill_nonempty = (byte_cnt_q != '0) || (wr_n != 2'd0);
  end

  // Emission control: decide whether the held NAL is handed off or discarded
  always_comb begin
`ifdef NAL_SLICE_FILTER_EN
    keep = (buf_q[0][4:0] >= 5'd1) && (buf_q[0][4:0] <= 5'd5);
`else
    keep = 1'b1;
`endif
    emit_fire  = (state_q == EMIT) && keep && out_ready;
    emit_leave = (state_q == EMIT) && (!keep || out_ready);
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT: begin
        if (accept && is_sc) state_d = FILL;
      end
      FILL: begin
        if (accept) begin
          if (in_last) begin
            state_d = fill_nonempty ? EMIT : HUNT;
          end else if (is_sc && (byte_cnt_q != '0)) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (emit_leave) state_d = done_last_q ? HUNT : FILL;
      end
      default: state_d = HUNT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // Working buffer, byte counter, zero run and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NAL_BYTES); i++) buf_q[i] <= 8'h00;
      zero_cnt_q  <= 2'd0;
      byte_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
      done_last_q <= 1'b0;
    end else if (emit_leave) begin
      for (int i = 0; i < int'(NAL_BYTES); i++) buf_q[i] <= 8'h00;
      zero_cnt_q  <= 2'd0;
      byte_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
      done_last_q <= 1'b0;
    end else if (accept) begin
      if (state_q == HUNT) begin
        if (is_sc) begin
          for (int i = 0; i < int'(NAL_BYTES); i++) buf_q[i] <= 8'h00;
          zero_cnt_q <= 2'd0;
          byte_cnt_q <= '0;
          ovf_q      <= 1'b0;
          perr_q     <= 1'b0;
        end else if (is_zero) begin
          zero_cnt_q <= zc_inc;
        end else begin
          zero_cnt_q <= 2'd0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if ((2'(k) < wr_n) && (widx[k] < SUM_W'(NAL_BYTES))) begin
            buf_q[IDX_W'(widx[k])] <= wb[k];
          end
        end
        byte_cnt_q <= cnt_sat;
        if (ovf_set)  ovf_q  <= 1'b1;
        if (perr_set) perr_q <= 1'b1;
        // Pending zeros ahead of a start code or end of stream are trailing zeros
        if (is_sc || in_last) zero_cnt_q <= 2'd0;
        else if (is_zero)     zero_cnt_q <= zc_inc;
        else                  zero_cnt_q <= 2'd0;
        if (in_last && fill_nonempty) done_last_q <= 1'b1;
      end
    end
  end

  // Flatten the working buffer MSB-first for the output register
  always_comb begin
    buf_flat = '0;
    for (int i = 0; i < int'(NAL_BYTES); i++) begin
      buf_flat[UNI_W-1-8*i -: 8] = buf_q[i];
    end
  end

  // Output register: held from one emission to the next
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready <= 1'b1;
      start    <= 1'b0;
      nal_unit <= '0;
      nal_len  <= '0;
      error    <= 1'b0;
    end else begin
      in_ready <= (state_d != EMIT);
      start    <= emit_fire;
      if (emit_fire) begin
        nal_unit <= buf_flat;
        nal_len  <= byte_cnt_q;
        error    <= ovf_q | perr_q;
      end
    end
  end

endmodule
